// File: rtl/csa8_operand_seq.sv
// csa8_operand_seq
//
// Byte-serial operand sequencer and result capture stage wrapped around an
// external combinational 8-bit carry-select adder. Operand bytes arrive as
// A then B pairs, LS pair first. The pair is presented to the adder from
// registers, and the sum and carry-out are captured one cycle later. Carry
// is chained from one pair to the next, so multi-byte words add LSB-first.
// A subtract is done as A + ~B + 1.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    upstream byte handshake
//   in_data              operand byte (A byte, then B byte)
//   in_last              taken with the B byte; marks the word's MS pair
//   op_sub               taken with the A byte of a word's first pair
//   add_a/add_b/add_cin  registered operands to the adder
//   add_sum/add_cout     combinational adder result
//   out_valid/out_ready  downstream result handshake
//   out_data/out_cout    result byte and its carry-out (subtract: 1 = no borrow)
//   out_last/out_idx     final-byte flag and byte position (0 = LS byte)

module csa8_operand_seq #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             op_sub,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_cin,
  input  logic [7:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_cout,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_ADD = 2'd2,
    S_OUT = 2'd3
  } state_t;

  state_t           state;
  logic             cy;
  logic             sub_q;
  logic             first_q;
  logic             last_q;
  logic [IDX_W-1:0] idx_q;

  // Operand bytes are only accepted while collecting A or B; the result
  // path never overlaps with the next pair.
  assign in_ready = (state == S_A) || (state == S_B);

  // Main sequencer. The first pair of a word latches the subtract mode and
  // seeds carry-in with it (the +1 of the two's complement); later pairs
  // reuse the latched mode and take the previous pair's carry-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_A;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cout  <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      cy        <= 1'b0;
      sub_q     <= 1'b0;
      first_q   <= 1'b1;
      last_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      case (state)
        S_A: begin
          if (in_valid) begin
            add_a <= in_data;
            if (first_q) begin
              sub_q <= op_sub;
            end
            state <= S_B;
          end
        end
        S_B: begin
          if (in_valid) begin
            add_b   <= sub_q ? ~in_data : in_data;
            add_cin <= first_q ? sub_q : cy;
            last_q  <= in_last;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          // Adder inputs have been stable for a full cycle here.
          out_data  <= add_sum;
          out_cout  <= add_cout;
          out_last  <= last_q;
          out_idx   <= idx_q;
          cy        <= add_cout;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_A;
            if (out_last) begin
              first_q <= 1'b1;
              idx_q   <= '0;
            end else begin
              // idx_q wraps silently; carry keeps chaining across the wrap.
              first_q <= 1'b0;
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_csa8_operand_seq.sv
// tb_csa8_operand_seq
//
// Self-checking bench for csa8_operand_seq. A behavioural 8-bit adder is
// attached to the add_* ports. Expected result bytes are pushed to a
// scoreboard queue as each byte pair is driven and popped when the DUT
// presents a result.

module tb_csa8_operand_seq;

  localparam int IDX_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             op_sub;
  logic [7:0]       add_a;
  logic [7:0]       add_b;
  logic             add_cin;
  logic [7:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_cout;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [7:0]       data;
    logic             cout;
    logic             last;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t sb[$];

  // Reference model state for the scoreboard
  logic             m_cy;
  logic             m_first;
  logic             m_sub;
  logic [IDX_W-1:0] m_idx;

  csa8_operand_seq #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .op_sub    (op_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  // Stand-in for the combinational adder core
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cy    = 1'b0;
    m_first = 1'b1;
    m_sub   = 1'b0;
    m_idx   = '0;
    sb.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one byte and wait (bounded) for it to be accepted.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic sub);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    op_sub   = sub;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    op_sub   = 1'b0;
  endtask

  // Drive an A/B pair, push the expected result, and check the registered
  // adder operands and that the result is not yet valid.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b,
                           input logic last, input logic sub);
    logic       s;
    logic [7:0] bb;
    logic       cin;
    logic [8:0] r;
    exp_t       e;
    s   = m_first ? sub : m_sub;
    bb  = s ? ~b : b;
    cin = m_first ? s : m_cy;
    r   = {1'b0, a} + {1'b0, bb} + {8'b0, cin};
    e.data = r[7:0];
    e.cout = r[8];
    e.last = last;
    e.idx  = m_idx;
    sb.push_back(e);
    m_sub = s;
    m_cy  = r[8];
    if (last) begin
      m_first = 1'b1;
      m_idx   = '0;
    end else begin
      m_first = 1'b0;
      m_idx   = m_idx + 1'b1;
    end
    send_byte(a, 1'b0, sub);
    send_byte(b, last, 1'b0);
    tests_run++;
    if ({add_a, add_b, add_cin} !== {a, bb, cin}) begin
      tests_failed++;
      $display("[TB] FAIL operands: a=%h b=%h cin=%b required a=%h b=%h cin=%b",
               add_a, add_b, add_cin, a, bb, cin);
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL early_valid: out_valid=%b in_ready=%b required 0 0",
               out_valid, in_ready);
    end
  endtask

  // Wait for a result, compare it with the scoreboard head, optionally hold
  // off the downstream for a few cycles, then complete the handshake.
  task automatic take_result(input int hold);
    int   n;
    exp_t e;
    exp_t got;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL result_timeout: out_valid=%b required 1", out_valid);
      return;
    end
    tests_run++;
    if (n != 1) begin
      tests_failed++;
      $display("[TB] FAIL latency: extra cycles=%0d required 1", n);
    end
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: result %h with nothing expected", out_data);
    end else begin
      e   = sb.pop_front();
      got = {out_data, out_cout, out_last, out_idx};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("[TB] FAIL result: data=%h cout=%b last=%b idx=%0d required data=%h cout=%b last=%b idx=%0d",
                 out_data, out_cout, out_last, out_idx, e.data, e.cout, e.last, e.idx);
      end
    end
    for (int i = 0; i < hold; i++) begin
      got = {out_data, out_cout, out_last, out_idx};
      tick();
      tests_run++;
      if ({out_data, out_cout, out_last, out_idx} !== got || out_valid !== 1'b1 ||
          in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hold: data=%h valid=%b in_ready=%b required data=%h valid=1 in_ready=0",
                 out_data, out_valid, in_ready, got.data);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tests_run++;
    if ({add_a, add_b, add_cin, out_valid, out_data, out_cout, out_last, out_idx} !== '0 ||
        in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: a=%h b=%h cin=%b valid=%b data=%h cout=%b last=%b idx=%0d in_ready=%b required all 0, in_ready=1",
               add_a, add_b, add_cin, out_valid, out_data, out_cout, out_last, out_idx, in_ready);
    end
  endtask

  task automatic test_single_add();
    send_pair(8'h12, 8'h34, 1'b1, 1'b0);
    tests_run++;
    if (add_sum !== 8'h46) begin
      tests_failed++;
      $display("[TB] FAIL single_add_sum: sum=%h required 46", add_sum);
    end
    take_result(0);
    tests_run++;
    if ({out_data, out_cout, out_last, out_idx} !== {8'h46, 1'b0, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("[TB] FAIL single_add_out: data=%h cout=%b last=%b idx=%0d required 46 0 1 0",
               out_data, out_cout, out_last, out_idx);
    end
  endtask

  task automatic test_two_byte();
    send_pair(8'hFF, 8'h01, 1'b0, 1'b0);
    take_result(0);
    tests_run++;
    if ({out_data, out_cout, out_idx} !== {8'h00, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("[TB] FAIL two_byte_lo: data=%h cout=%b idx=%0d required 00 1 0",
               out_data, out_cout, out_idx);
    end
    send_pair(8'h01, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (add_cin !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL two_byte_cin: add_cin=%b required 1", add_cin);
    end
    take_result(0);
    tests_run++;
    if ({out_data, out_cout, out_last, out_idx} !== {8'h02, 1'b0, 1'b1, 4'd1}) begin
      tests_failed++;
      $display("[TB] FAIL two_byte_hi: data=%h cout=%b last=%b idx=%0d required 02 0 1 1",
               out_data, out_cout, out_last, out_idx);
    end
  endtask

  task automatic test_subtract();
    send_pair(8'h05, 8'h07, 1'b1, 1'b1);
    tests_run++;
    if (add_b !== 8'hF8 || add_cin !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sub_operands: add_b=%h add_cin=%b required F8 1", add_b, add_cin);
    end
    take_result(0);
    tests_run++;
    if (out_data !== 8'hFE || out_cout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sub_result: data=%h cout=%b required FE 0", out_data, out_cout);
    end
    send_pair(8'h01, 8'h01, 1'b1, 1'b0);
    tests_run++;
    if (add_cin !== 1'b0 || add_b !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL add_after_sub: add_b=%h add_cin=%b required 01 0", add_b, add_cin);
    end
    take_result(0);
  endtask

  task automatic test_backpressure();
    send_pair(8'hA5, 8'h5A, 1'b1, 1'b0);
    take_result(5);
  endtask

  task automatic test_reset_mid();
    // Leave a pending carry and non-first state behind, then abandon a word.
    send_pair(8'hFF, 8'h01, 1'b0, 1'b1);
    take_result(0);
    send_byte(8'h77, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tests_run++;
    if ({add_a, add_b, add_cin, out_valid, out_data, out_cout, out_last, out_idx} !== '0 ||
        in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_state: a=%h b=%h cin=%b valid=%b data=%h idx=%0d in_ready=%b required all 0, in_ready=1",
               add_a, add_b, add_cin, out_valid, out_data, out_idx, in_ready);
    end
    send_pair(8'h10, 8'h20, 1'b1, 1'b0);
    tests_run++;
    if (add_cin !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_cin: add_cin=%b required 0", add_cin);
    end
    take_result(0);
    tests_run++;
    if (out_data !== 8'h30 || out_idx !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_result: data=%h idx=%0d required 30 0", out_data, out_idx);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut.state !== dut.S_A) begin
        tests_failed++;
        $display("[TB] FAIL idle: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    logic sub;
    // A few random words, then one long word that wraps the byte index.
    for (int w = 0; w < 6; w++) begin
      len = (w == 5) ? 18 : int'($urandom_range(1, 3));
      sub = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        send_pair(8'($urandom), 8'($urandom), k == len - 1, sub);
        take_result(int'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    in_last      = 1'b0;
    op_sub       = 1'b0;
    out_ready    = 1'b0;
    model_reset();
    test_reset();
    test_single_add();
    test_two_byte();
    test_subtract();
    test_backpressure();
    test_reset_mid();
    test_idle();
    test_back_to_back();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
